// File: rtl/acc_inst_fifo.sv
// Instruction queue front end: AXI4-Lite slave writes 32-bit words into a
// first-word-fall-through FIFO popped by the decoder; slave reads return occupancy.
module acc_inst_fifo #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 5
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] s_nasti_aw_addr,
   input  logic                  s_nasti_aw_valid,
   output logic                  s_nasti_aw_ready,
   input  logic [DATA_WIDTH-1:0] s_nasti_w_data,
   input  logic [3:0]            s_nasti_w_strb,
   input  logic                  s_nasti_w_valid,
   output logic                  s_nasti_w_ready,
   output logic [1:0]            s_nasti_b_resp,
   output logic                  s_nasti_b_valid,
   input  logic                  s_nasti_b_ready,
   input  logic [ADDR_WIDTH-1:0] s_nasti_ar_addr,
   input  logic                  s_nasti_ar_valid,
   output logic                  s_nasti_ar_ready,
   output logic [DATA_WIDTH-1:0] s_nasti_r_data,
   output logic [1:0]            s_nasti_r_resp,
   output logic                  s_nasti_r_valid,
   input  logic                  s_nasti_r_ready,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  full,
   output logic                  empty
);

   localparam int ENTRIES = 1 << DEPTH;
   localparam logic [DEPTH:0] COUNT_MAX = (DEPTH+1)'(ENTRIES);

   function automatic logic [DATA_WIDTH-1:0] status_word(input logic [DEPTH:0] c);
      status_word = '0;
      status_word[DEPTH:0] = c;
   endfunction

   logic [DATA_WIDTH-1:0] mem [ENTRIES];
   logic [DEPTH-1:0]      wr_ptr, rd_ptr;
   logic [DEPTH:0]        count, count_nxt;
   logic                  full_q, empty_q;
   logic                  b_valid_q, r_valid_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic                  wr_fire, ar_fire, push, pop;
   logic                  unused_addr;

   assign unused_addr = ^{s_nasti_aw_addr, s_nasti_ar_addr};

   // Write handshake only while no response is outstanding, so one write per two cycles
   assign wr_fire = s_nasti_aw_valid & s_nasti_w_valid & ~b_valid_q;
   assign ar_fire = s_nasti_ar_valid & ~r_valid_q;
   assign push    = wr_fire & (s_nasti_w_strb == 4'hF) & ~full_q;
   assign pop     = r_en & ~empty_q;

   assign s_nasti_aw_ready = wr_fire;
   assign s_nasti_w_ready  = wr_fire;
   assign s_nasti_b_resp   = 2'b00;
   assign s_nasti_b_valid  = b_valid_q;
   assign s_nasti_ar_ready = ~r_valid_q;
   assign s_nasti_r_data   = r_data_q;
   assign s_nasti_r_resp   = 2'b00;
   assign s_nasti_r_valid  = r_valid_q;

   assign r_data = mem[rd_ptr];
   assign full   = full_q;
   assign empty  = empty_q;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + (DEPTH+1)'(1);
         2'b01:   count_nxt = count - (DEPTH+1)'(1);
         default: count_nxt = count;
      endcase
   end

   // Storage carries no reset; contents are meaningless until written
   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr] <= s_nasti_w_data;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + DEPTH'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH'(1);
         count   <= count_nxt;
         full_q  <= (count_nxt == COUNT_MAX);
         empty_q <= (count_nxt == '0);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         b_valid_q <= 1'b0;
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
      end else begin
         if (wr_fire)
            b_valid_q <= 1'b1;
         else if (s_nasti_b_ready)
            b_valid_q <= 1'b0;
         if (ar_fire) begin
            r_valid_q <= 1'b1;
            r_data_q  <= status_word(count);
         end else if (s_nasti_r_ready) begin
            r_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_acc_inst_fifo.sv
// Directed bench for acc_inst_fifo: host writes, status reads, pops, wrap, reset.
module tb_acc_inst_fifo;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [63:0] aw_addr, ar_addr;
   logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic        ar_valid, ar_ready, r_valid, r_ready;
   logic [31:0] w_data, s_r_data, r_data;
   logic [3:0]  w_strb;
   logic [1:0]  b_resp, r_resp;
   logic        r_en, full, empty;

   int errors = 0;
   int checks = 0;
   logic [31:0] st;
   logic [31:0] got[$];

   always #5 aclk = ~aclk;

   acc_inst_fifo #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .DEPTH(5)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_nasti_aw_addr(aw_addr), .s_nasti_aw_valid(aw_valid), .s_nasti_aw_ready(aw_ready),
      .s_nasti_w_data(w_data), .s_nasti_w_strb(w_strb),
      .s_nasti_w_valid(w_valid), .s_nasti_w_ready(w_ready),
      .s_nasti_b_resp(b_resp), .s_nasti_b_valid(b_valid), .s_nasti_b_ready(b_ready),
      .s_nasti_ar_addr(ar_addr), .s_nasti_ar_valid(ar_valid), .s_nasti_ar_ready(ar_ready),
      .s_nasti_r_data(s_r_data), .s_nasti_r_resp(r_resp),
      .s_nasti_r_valid(r_valid), .s_nasti_r_ready(r_ready),
      .r_en(r_en), .r_data(r_data), .full(full), .empty(empty)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      aw_valid = 1'b1; w_valid = 1'b1; w_data = d; w_strb = s;
      @(negedge aclk);
      while (!(aw_ready && w_ready) && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check("wr_hs_ready", {aw_ready, w_ready}, 2'b11);
      @(posedge aclk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      check("wr_bvalid", b_valid, 1'b1);
      check("wr_bresp", b_resp, 2'b00);
      b_ready = 1'b1;
      @(posedge aclk); #1;
      b_ready = 1'b0;
      check("wr_bvalid_clr", b_valid, 1'b0);
   endtask

   task automatic axi_read(output logic [31:0] v);
      int n = 0;
      ar_valid = 1'b1;
      @(negedge aclk);
      while (!ar_ready && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check("rd_arready", ar_ready, 1'b1);
      @(posedge aclk); #1;
      ar_valid = 1'b0;
      check("rd_rvalid", r_valid, 1'b1);
      check("rd_rresp", r_resp, 2'b00);
      v = s_r_data;
      r_ready = 1'b1;
      @(posedge aclk); #1;
      r_ready = 1'b0;
      check("rd_rvalid_clr", r_valid, 1'b0);
   endtask

   task automatic pop_check(input logic [31:0] exp);
      check("pop_notempty", empty, 1'b0);
      check("pop_data", r_data, exp);
      r_en = 1'b1;
      @(posedge aclk); #1;
      r_en = 1'b0;
   endtask

   task automatic rec();
      if (r_en && !empty) got.push_back(r_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      aw_addr = 64'h0; ar_addr = 64'h0;
      aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0;
      w_data = '0; w_strb = '0; r_en = 0;
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;

      // Reset state and first status read
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_bvalid", b_valid, 1'b0);
      check("rst_rvalid", r_valid, 1'b0);
      check("rst_rdata", s_r_data, 32'h0);
      axi_read(st);
      check("rst_status", st, 32'd0);

      // Three words in, status, three pops
      axi_write(32'h0000_0088, 4'hF);
      axi_write(32'h0000_0102, 4'hF);
      axi_write(32'hDEAD_BEEF, 4'hF);
      axi_read(st);
      check("status3", st, 32'd3);
      pop_check(32'h0000_0088);
      pop_check(32'h0000_0102);
      pop_check(32'hDEAD_BEEF);
      check("empty_after3", empty, 1'b1);

      // Fill to 32, then one write while full
      for (int i = 0; i < 32; i++) begin
         check("fill_notfull", full, 1'b0);
         axi_write(32'(i), 4'hF);
      end
      check("full_at32", full, 1'b1);
      axi_read(st);
      check("status32", st, 32'd32);
      axi_write(32'd32, 4'hF);
      check("full_after33", full, 1'b1);
      axi_read(st);
      check("status32_again", st, 32'd32);
      for (int i = 0; i < 32; i++) pop_check(32'(i));
      check("empty_after_drain", empty, 1'b1);
      check("notfull_after_drain", full, 1'b0);

      // Partial strobe is dropped
      axi_write(32'h1234_5678, 4'h7);
      check("partial_empty", empty, 1'b1);
      axi_read(st);
      check("partial_status", st, 32'd0);

      // Streaming with continuous pop, across pointer wrap
      axi_write(32'h5000_0000, 4'hF);
      got.delete();
      r_en = 1'b1;
      for (int i = 1; i <= 75; i++) begin
         logic fired;
         int n;
         fired = 1'b0;
         n = 0;
         aw_valid = 1'b1; w_valid = 1'b1; w_data = 32'h5000_0000 + 32'(i); w_strb = 4'hF;
         while (!fired && n < 20) begin
            @(negedge aclk);
            rec();
            fired = aw_ready;
            @(posedge aclk); #1;
            n++;
         end
         aw_valid = 1'b0; w_valid = 1'b0;
         check("stream_fired", fired, 1'b1);
         b_ready = 1'b1;
         @(negedge aclk);
         rec();
         @(posedge aclk); #1;
         b_ready = 1'b0;
      end
      repeat (3) begin
         @(negedge aclk);
         rec();
         @(posedge aclk); #1;
      end
      r_en = 1'b0;
      check("stream_count", got.size(), 76);
      for (int k = 0; k < got.size() && k < 76; k++)
         check("stream_word", got[k], 32'h5000_0000 + 32'(k));
      check("stream_empty", empty, 1'b1);

      // Asynchronous reset with count 5 and a write response pending
      for (int i = 0; i < 4; i++) axi_write(32'hA0 + 32'(i), 4'hF);
      aw_valid = 1'b1; w_valid = 1'b1; w_data = 32'hA4; w_strb = 4'hF;
      @(posedge aclk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      check("pre_rst_bvalid", b_valid, 1'b1);
      axi_read(st);
      check("pre_rst_status", st, 32'd5);
      #2 aresetn = 1'b0;
      #1;
      check("async_rst_empty", empty, 1'b1);
      check("async_rst_full", full, 1'b0);
      check("async_rst_bvalid", b_valid, 1'b0);
      check("async_rst_rvalid", r_valid, 1'b0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      axi_write(32'hCAFE_F00D, 4'hF);
      check("post_rst_notempty", empty, 1'b0);
      axi_read(st);
      check("post_rst_status", st, 32'd1);
      pop_check(32'hCAFE_F00D);
      check("post_rst_empty", empty, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
